mem_responder: RTL

Memory-side responder for the multi-cycle CPU's instruction-fetch and data-memory accesses. The stage sequencer issues one request per IF or MEM stage; this block accepts it, inserts a programmable number of wait states, performs the access on an internal word-addressed RAM, and returns a one-cycle response pulse. The sequencer's IF_WAIT and MEM_WAIT stages run off that pulse instead of a fixed cycle count.

---
 rtl/mem_responder_if.sv | 25 ++
 rtl/mem_responder.sv | 97 +++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between the stage sequencer and mem_responder
// master: sequencer side, drives req_valid/req_wren/req_addr/req_wdata
//         and samples req_ready/rsp_valid/rsp_rdata/busy/err
// slave : responder side, the mirror image
interface mem_responder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_wren;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              busy;
    logic              err;
    modport master (
        output req_valid, req_wren, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy, err
    );
    modport slave (
        input  req_valid, req_wren, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory responder for IF/MEM accesses of the multi-cycle CPU
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      mem_responder_if.slave: req_valid/req_wren/req_addr/req_wdata in,
//            req_ready/rsp_valid/rsp_rdata/busy/err out
// Build option MEM_RESPONDER_ALIGN_CHECK_EN: flag misaligned accesses on err,
// suppress misaligned writes and return zero data for them.
module mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input logic            clk,
    input logic            reset_n,
    mem_responder_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] RESP    = 2'd2;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
    logic [1:0]            state;
    logic [1:0]            state_nx;
    logic [3:0]            cnt;
    logic                  wren_q;
    logic [DEPTH_LOG2-1:0] word_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic [31:0]           mem [2**DEPTH_LOG2];
    logic                  accept;
    logic                  enter_resp;
    logic                  acc_wren;
    logic                  acc_bad;
    logic [DEPTH_LOG2-1:0] acc_word;
    logic [31:0]           acc_wdata;
    logic                  addr_unused;
    assign accept     = state == IDLE && bus.req_valid;
    always_comb begin
        state_nx = accept        ? (WAIT_CYCLES == 0 ? RESP : WAIT) :
                   state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) :
                   IDLE;
    end
    assign enter_resp = state_nx == RESP;
    // With zero wait states the access happens on the accept edge itself,
    // so the live request is used instead of the latched copy.
    assign acc_wren   = state == IDLE ? bus.req_wren : wren_q;
    assign acc_word   = state == IDLE ? bus.req_addr[DEPTH_LOG2+1:2] : word_q;
    assign acc_wdata  = state == IDLE ? bus.req_wdata : wdata_q;
    // Address bits outside the word index are deliberately ignored (aliasing).
    assign addr_unused = ^bus.req_addr;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    logic bad_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bad_q <= 1'b0;
        else if (accept)
            bad_q <= bus.req_addr[1:0] != 2'b00;
    end
    assign acc_bad = state == IDLE ? bus.req_addr[1:0] != 2'b00 : bad_q;
    assign bus.err = state == RESP && bad_q;
`else
    assign acc_bad = 1'b0;
    assign bus.err = 1'b0;
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            wren_q  <= 1'b0;
            word_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt     <= WAIT_LD;
                wren_q  <= bus.req_wren;
                word_q  <= bus.req_addr[DEPTH_LOG2+1:2];
                wdata_q <= bus.req_wdata;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp)
                rdata_q <= acc_bad ? 32'h0 : acc_wren ? acc_wdata : mem[acc_word];
        end
    end
    // RAM is not reset; the reset_n term keeps a request presented during
    // reset from committing.
    always_ff @(posedge clk) begin
        if (reset_n && enter_resp && acc_wren && !acc_bad)
            mem[acc_word] <= acc_wdata;
    end
    assign bus.req_ready = state == IDLE;
    assign bus.busy      = state != IDLE;
    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_rdata = rdata_q;
endmodule
